mbist_march_ctrl: RTL and testbench
===================================

# mbist_march_ctrl

MBIST March C- controller. Drives the single-port `fault_mem` interface (`write_read`, `address`, `wdata`, `rdata`) and checks every read against the expected background. It sits between the test-mode start request and the memory under test. It reports pass/fail, and for the first mismatch it reports the failing address, march element and bit syndrome.

## Interface
- `DATA_WIDTH`, 8, memory word width
- `ADDR_WIDTH`, 4, memory address width
- `CAPACITY`, 15, highest valid address; the test covers addresses 0..CAPACITY (N = CAPACITY+1 words)

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `start` in 1: level request; sampled only in IDLE
- `write_read` out 1: 1 = write, 0 = read, to memory
- `address` out ADDR_WIDTH: memory address
- `wdata` out DATA_WIDTH: write data, leads its write by one cycle (see Timing)
- `rdata` in DATA_WIDTH: memory read data, 2-cycle latency
- `busy` out 1: high in RUN and DRAIN
- `done` out 1: high in DONE
- `fail` out 1: sticky; at least one mismatch in the current run
- `fail_addr` out ADDR_WIDTH: address of the first mismatch
- `fail_elem` out 3: march element (0..5) of the first mismatch
- `fail_syndrome` out DATA_WIDTH: `rdata` XOR expected at the first mismatch

## Operation
- **Sequence**, with backgrounds 0 = all-zeros and 1 = all-ones:
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
- **Total:** 10·N operations, one per cycle, with no bubbles between elements.
- **Within an address:** the read precedes the write on consecutive cycles.
- **Address counter:**
  - ⇑ elements run 0→CAPACITY.
  - ⇓ elements run CAPACITY→0.
  - The element advances when the counter reaches its end value on the last op.
- **FSM:**
  - IDLE→RUN on `start`=1.
  - RUN→DRAIN after the last E5 read is issued.
  - DRAIN lasts exactly 2 cycles, then goes to DONE.
  - DONE→IDLE when `start`=0.
  - With `start` held high, the FSM stays in DONE.
- **Check pipeline:** each issued read pushes {expected, address, element} into a 2-stage delay. When the stage-2 entry is valid, `rdata` is compared against it.
- **First mismatch:**
  - Sets `fail`.
  - Loads `fail_addr`, `fail_elem` and `fail_syndrome`.
  - Later mismatches leave the capture registers untouched.
- **Start of a run:** leaving IDLE clears `fail` and the capture registers.
- **Results:** hold through DONE and IDLE until the next start.
- **Idle bus:** outside RUN, `write_read`=0 and `address`=0. These are harmless reads, and they never enter the check pipeline.

## Timing
- **Reset values:** at the first edge with `rst_n`=0, the FSM goes to IDLE and all outputs go to 0 (`write_read`, `address`, `wdata`, `busy`, `done`, `fail`, `fail_addr`, `fail_elem`, `fail_syndrome`). The check pipeline valids are cleared.
- **Reset mid-run:** same result; in-flight reads are discarded.
- **Write data lead:**
  - The memory registers `wdata` one cycle before it commits the write.
  - Therefore `wdata` in cycle t equals the data of the operation presented in cycle t+1.
  - In IDLE, `wdata`=0, which satisfies E0's first write.
- **Read latency:**
  - A read issued in cycle t (edge at end of t) has `rdata` valid in cycle t+2.
  - The compare occurs at the edge ending cycle t+2.
- **Run length:**
  - `start` sampled at edge e0; the first op is presented in the cycle after e0.
  - `busy` rises with RUN and stays high for 10·N + 2 cycles.
  - `done` rises in the next cycle.
- **Read/write order:** a write at edge k followed by a read of the same address at edge k+1 returns the new data. The E2→E3 turn at address CAPACITY relies on this.

## Configuration
- **`MBIST_STOP_ON_FAIL_EN` defined:**
  - On the first mismatch, RUN or DRAIN goes immediately to DONE.
  - No further operations are issued after that compare edge.
  - `busy` drops in the same cycle as `done` rises.
- **Undefined:** the full sequence always completes, and only the first failure is captured.

## Test plan
1. **Fault-free memory** (N=16, width 8), `start` pulse: 160 ops; `busy` high 162 cycles; `done`=1, `fail`=0; final memory contents all 0x00.
2. **Bit 2 of address 5 stuck at 1:** `fail`=1, `fail_elem`=1, `fail_addr`=5, `fail_syndrome`=0x04.
3. **Bit 7 of address 10 stuck at 0:** `fail_elem`=2, `fail_addr`=10, `fail_syndrome`=0x80. With `MBIST_STOP_ON_FAIL_EN`, `done` rises 2 cycles after that read is issued.
4. **Protocol checks:**
   - Monitor confirms E3/E4 address order is 15→0.
   - Every write's data equals the previous cycle's `wdata`.
   - Zero idle cycles between elements.
5. **Reset mid-run:** `rst_n`=0 for one cycle at op 50 → all outputs 0 at the next edge and the FSM is in IDLE. A restart then completes cleanly with `fail`=0.
6. **Start handling:**
   - `start` held high through completion: the FSM stays in DONE.
   - `start` dropped: IDLE, with results retained.
   - A second `start`: clears `fail` and runs again.

Source files
------------

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller with first-failure capture.
// Optional `MBIST_STOP_ON_FAIL_EN ends the run at the first mismatching compare.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syndrome
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(CAPACITY);

  logic [1:0]            state, nxt_state;
  logic [2:0]            elem, nxt_elem;
  logic [ADDR_WIDTH-1:0] addr, nxt_addr;
  logic                  phase, nxt_phase;
  logic                  drain_cnt, nxt_drain_cnt;

  logic                  s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [2:0]            s1_elem, s2_elem;

  logic                  two_op, elem_down, op_write, last_at_addr, read_ones;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic [2:0]            elem_inc;
  logic                  mismatch, stop_hit, active;
  logic                  nxt_two_op, nxt_write, nxt_write_ones;

  // phase selects read (0) or write (1) inside the two-op elements E1..E4
  always_comb begin
    two_op       = (elem >= 3'd1) && (elem <= 3'd4);
    elem_down    = (elem == 3'd3) || (elem == 3'd4);
    op_write     = (elem == 3'd0) || (two_op && phase);
    last_at_addr = !two_op || phase;
    read_ones    = (elem == 3'd2) || (elem == 3'd4);
    end_addr     = elem_down ? '0 : ADDR_LAST;
    elem_inc     = elem + 3'd1;
    active       = (state == S_RUN) || (state == S_DRAIN);
    mismatch     = active && s2_valid && (rdata != s2_exp);
  end

`ifdef MBIST_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  always_comb begin
    nxt_state     = state;
    nxt_elem      = elem;
    nxt_addr      = addr;
    nxt_phase     = phase;
    nxt_drain_cnt = drain_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_RUN;
          nxt_elem  = 3'd0;
          nxt_addr  = '0;
          nxt_phase = 1'b0;
        end
      end
      S_RUN: begin
        if (!last_at_addr) begin
          nxt_phase = 1'b1;
        end else begin
          nxt_phase = 1'b0;
          if (addr == end_addr) begin
            if (elem == 3'd5) begin
              nxt_state     = S_DRAIN;
              nxt_drain_cnt = 1'b0;
            end else begin
              nxt_elem = elem_inc;
              nxt_addr = ((elem_inc == 3'd3) || (elem_inc == 3'd4)) ? ADDR_LAST : '0;
            end
          end else begin
            nxt_addr = elem_down ? addr - 1'b1 : addr + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt) nxt_state = S_DONE;
        else           nxt_drain_cnt = 1'b1;
      end
      default: begin
        if (!start) nxt_state = S_IDLE;
      end
    endcase
    if (stop_hit) nxt_state = S_DONE;
    if (!rst_n)   nxt_state = S_IDLE;
  end

  // The memory registers wdata a cycle early, so drive the data of the next op
  always_comb begin
    nxt_two_op     = (nxt_elem >= 3'd1) && (nxt_elem <= 3'd4);
    nxt_write      = (nxt_state == S_RUN) && ((nxt_elem == 3'd0) || (nxt_two_op && nxt_phase));
    nxt_write_ones = (nxt_elem == 3'd1) || (nxt_elem == 3'd3);
    wdata          = (nxt_write && nxt_write_ones) ? '1 : '0;
  end

  assign write_read = (state == S_RUN) && op_write;
  assign address    = (state == S_RUN) ? addr : '0;
  assign busy       = active;
  assign done       = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      elem      <= 3'd0;
      addr      <= '0;
      phase     <= 1'b0;
      drain_cnt <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_exp    <= '0;
      s2_exp    <= '0;
      s1_addr   <= '0;
      s2_addr   <= '0;
      s1_elem   <= 3'd0;
      s2_elem   <= 3'd0;
    end else begin
      state     <= nxt_state;
      elem      <= nxt_elem;
      addr      <= nxt_addr;
      phase     <= nxt_phase;
      drain_cnt <= nxt_drain_cnt;
      s1_valid  <= (state == S_RUN) && !op_write;
      s1_exp    <= read_ones ? '1 : '0;
      s1_addr   <= addr;
      s1_elem   <= elem;
      s2_valid  <= s1_valid;
      s2_exp    <= s1_exp;
      s2_addr   <= s1_addr;
      s2_elem   <= s1_elem;
    end
  end

  // Only the first mismatch of a run is captured; a new start clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_elem     <= 3'd0;
      fail_syndrome <= '0;
    end else if ((state == S_IDLE) && start) begin
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_elem     <= 3'd0;
      fail_syndrome <= '0;
    end else if (mismatch && !fail) begin
      fail          <= 1'b1;
      fail_addr     <= s2_addr;
      fail_elem     <= s2_elem;
      fail_syndrome <= rdata ^ s2_exp;
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Testbench for mbist_march_ctrl: behavioural fault_mem model with stuck-at
// injection, vector table of fault cases, plus reset and start-handling sequences.
module tb_mbist_march_ctrl;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int CAP  = 15;
  localparam int N    = CAP + 1;
  localparam int NOPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          write_read;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_syndrome;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_syndrome(fail_syndrome)
  );

  always #5 clk = ~clk;

  // fault_mem model: wdata registered one cycle ahead, 2-cycle read latency
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wdata_q, rd_q1, rd_q2;
  int            fault_a = -1;
  logic [DW-1:0] sa1_mask = '0;
  logic [DW-1:0] sa0_mask = '0;

  function automatic logic [DW-1:0] cellRead(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem[a];
    if (int'(a) == fault_a) v = (v | sa1_mask) & ~sa0_mask;
    return v;
  endfunction

  always @(posedge clk) begin
    wdata_q <= wdata;
    if (write_read) mem[address] <= wdata_q;
    rd_q1 <= cellRead(address);
    rd_q2 <= rd_q1;
  end
  assign rdata = rd_q2;

  typedef struct {
    int         fault_a;
    logic [7:0] sa1;
    logic [7:0] sa0;
    logic       exp_fail;
    logic [2:0] exp_elem;
    logic [3:0] exp_addr;
    logic [7:0] exp_syn;
  } vec_t;

  vec_t vecs [6];

  bit         exp_we [NOPS];
  int         exp_ad [NOPS];
  logic [7:0] exp_wd [NOPS];

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic pushOp(inout int k, input bit we, input int a, input logic [7:0] d);
    exp_we[k] = we;
    exp_ad[k] = a;
    exp_wd[k] = d;
    k++;
  endtask

  // Reference March C- operation list, built straight from the element table
  task automatic buildOps();
    int k;
    k = 0;
    for (int a = 0; a <= CAP; a++) pushOp(k, 1'b1, a, 8'h00);
    for (int a = 0; a <= CAP; a++) begin pushOp(k, 1'b0, a, 8'h00); pushOp(k, 1'b1, a, 8'hFF); end
    for (int a = 0; a <= CAP; a++) begin pushOp(k, 1'b0, a, 8'h00); pushOp(k, 1'b1, a, 8'h00); end
    for (int a = CAP; a >= 0; a--) begin pushOp(k, 1'b0, a, 8'h00); pushOp(k, 1'b1, a, 8'hFF); end
    for (int a = CAP; a >= 0; a--) begin pushOp(k, 1'b0, a, 8'h00); pushOp(k, 1'b1, a, 8'h00); end
    for (int a = 0; a <= CAP; a++) pushOp(k, 1'b0, a, 8'h00);
  endtask

  // Starts one run and follows it to DONE, comparing every issued op
  task automatic applyStimulus(input bit hold_start, output int busy_cycles,
                               output int op_errs, output int wd_errs, output bit timed_out);
    logic [DW-1:0] prev_wd;
    busy_cycles = 0;
    op_errs     = 0;
    wd_errs     = 0;
    timed_out   = 1'b1;
    @(negedge clk);
    start = 1'b1;
    #1 prev_wd = wdata;
    @(posedge clk);
    #1 if (!hold_start) start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (busy) begin
        if (busy_cycles < NOPS) begin
          if (write_read !== exp_we[busy_cycles] || address !== AW'(exp_ad[busy_cycles])) op_errs++;
          if (exp_we[busy_cycles] && prev_wd !== exp_wd[busy_cycles]) wd_errs++;
        end else if (write_read !== 1'b0) begin
          op_errs++;
        end
        busy_cycles++;
      end else if (done) begin
        timed_out = 1'b0;
        break;
      end else begin
        op_errs++;
      end
      prev_wd = wdata;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_write_read"}, write_read, 0);
    checkOutput({tag, "_address"}, address, 0);
    checkOutput({tag, "_wdata"}, wdata, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_fail"}, fail, 0);
    checkOutput({tag, "_fail_addr"}, fail_addr, 0);
    checkOutput({tag, "_fail_elem"}, fail_elem, 0);
    checkOutput({tag, "_fail_syndrome"}, fail_syndrome, 0);
  endtask

  task automatic setFault(input int a, input logic [7:0] s1, input logic [7:0] s0);
    fault_a  = a;
    sa1_mask = s1;
    sa0_mask = s0;
  endtask

  initial begin
    int  bc, oe, we_err, nz, ops_seen;
    bit  to;

    vecs[0] = '{-1, 8'h00, 8'h00, 1'b0, 3'd0, 4'd0,  8'h00};
    vecs[1] = '{ 5, 8'h04, 8'h00, 1'b1, 3'd1, 4'd5,  8'h04};
    vecs[2] = '{10, 8'h00, 8'h80, 1'b1, 3'd2, 4'd10, 8'h80};
    vecs[3] = '{ 0, 8'h01, 8'h00, 1'b1, 3'd1, 4'd0,  8'h01};
    vecs[4] = '{15, 8'h00, 8'h01, 1'b1, 3'd2, 4'd15, 8'h01};
    vecs[5] = '{ 3, 8'hFF, 8'h00, 1'b1, 3'd1, 4'd3,  8'hFF};
    buildOps();

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      setFault(vecs[v].fault_a, vecs[v].sa1, vecs[v].sa0);
      applyStimulus(1'b0, bc, oe, we_err, to);
      checkOutput($sformatf("v%0d_timeout", v), to, 0);
      checkOutput($sformatf("v%0d_busy_cycles", v), bc, NOPS + 2);
      checkOutput($sformatf("v%0d_op_sequence_errs", v), oe, 0);
      checkOutput($sformatf("v%0d_wdata_lead_errs", v), we_err, 0);
      checkOutput($sformatf("v%0d_fail", v), fail, vecs[v].exp_fail);
      checkOutput($sformatf("v%0d_fail_elem", v), fail_elem, vecs[v].exp_elem);
      checkOutput($sformatf("v%0d_fail_addr", v), fail_addr, vecs[v].exp_addr);
      checkOutput($sformatf("v%0d_fail_syndrome", v), fail_syndrome, vecs[v].exp_syn);
      if (v == 0) begin
        nz = 0;
        for (int a = 0; a < N; a++) if (mem[a] !== 8'h00) nz++;
        checkOutput("v0_final_mem_nonzero_words", nz, 0);
      end
    end

    // Reset in the middle of a failing run
    setFault(5, 8'h04, 8'h00);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ops_seen = 0;
    for (int cyc = 0; cyc < 200 && ops_seen < 50; cyc++) begin
      @(negedge clk);
      if (busy) ops_seen++;
    end
    checkOutput("midrun_ops_reached", ops_seen, 50);
    checkOutput("midrun_fail_before_reset", fail, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 checkAllZero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    setFault(-1, 8'h00, 8'h00);
    applyStimulus(1'b0, bc, oe, we_err, to);
    checkOutput("restart_timeout", to, 0);
    checkOutput("restart_busy_cycles", bc, NOPS + 2);
    checkOutput("restart_op_sequence_errs", oe, 0);
    checkOutput("restart_fail", fail, 0);

    // start held high through completion, then released
    setFault(10, 8'h00, 8'h80);
    applyStimulus(1'b1, bc, oe, we_err, to);
    checkOutput("held_timeout", to, 0);
    repeat (5) @(negedge clk);
    checkOutput("held_done_stays", done, 1);
    checkOutput("held_busy_low", busy, 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release_done_low", done, 0);
    checkOutput("release_busy_low", busy, 0);
    checkOutput("release_fail_kept", fail, 1);
    checkOutput("release_fail_addr_kept", fail_addr, 10);
    checkOutput("release_fail_elem_kept", fail_elem, 2);
    checkOutput("release_syndrome_kept", fail_syndrome, 8'h80);

    setFault(-1, 8'h00, 8'h00);
    applyStimulus(1'b0, bc, oe, we_err, to);
    checkOutput("second_timeout", to, 0);
    checkOutput("second_busy_cycles", bc, NOPS + 2);
    checkOutput("second_fail_cleared", fail, 0);
    checkOutput("second_fail_addr_cleared", fail_addr, 0);
    checkOutput("second_syndrome_cleared", fail_syndrome, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
